// File: rtl/spi_dac_multi_if.sv
// Sample handshake and DAC pad bundle for spi_dac_multi.
interface spi_dac_multi_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DATA_W   = 12
);
   logic [CHANNELS*DATA_W-1:0] sample_in;
   logic                       sample_valid;
   logic                       sample_ready;
   logic                       busy;
   logic                       spi_le;
   logic                       spi_clk;
   logic [CHANNELS-1:0]        spi_dat;
   logic                       frame_done;
   logic                       overrun;

   // Sample source / pad observer side
   modport master (
      output sample_in, sample_valid,
      input  sample_ready, busy, spi_le, spi_clk, spi_dat, frame_done, overrun
   );

   // Serialiser side
   modport slave (
      input  sample_in, sample_valid,
      output sample_ready, busy, spi_le, spi_clk, spi_dat, frame_done, overrun
   );
endinterface

// File: rtl/spi_dac_multi.sv
// Multi-channel serial front-end for DAC7611-style converters: all channels
// shift out in parallel on a shared SCLK/LE, one data line per channel.
// Optional macro SPI_DAC_PENDING_EN adds a one-deep pending sample buffer
// so frames can run back to back.
module spi_dac_multi #(
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DATA_W    = 12,
   parameter int unsigned CMD_W     = 4,
   parameter logic [31:0] CMD       = 32'b0011,
   parameter int unsigned CLK_DIV   = 1,
   parameter int unsigned LE_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst,
   spi_dac_multi_if.slave bus
);
   localparam int unsigned FW      = CMD_W + DATA_W;
   localparam int unsigned SW      = CHANNELS * DATA_W;
   localparam int unsigned CNT_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned BIT_W   = $clog2(FW + 1);
   // Command bits above the sample; with CMD_W=0 the shift pushes them all out
   localparam logic [FW-1:0] CMD_FRAME = FW'(64'(CMD) << DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        phase_q, phase_d;
   logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
   logic [CHANNELS-1:0][FW-1:0] shift_q, shift_d;
   logic                        ready_c;
   logic                        le_d, sclk_d, busy_d, done_d, ovr_d;
   logic [CHANNELS-1:0]         dat_d;
`ifdef SPI_DAC_PENDING_EN
   logic [SW-1:0]               pend_q, pend_d;
   logic                        pend_full_q, pend_full_d;
`endif

   // Prefix every channel's sample with the command bits
   function automatic logic [CHANNELS-1:0][FW-1:0] build_frame(input logic [SW-1:0] s);
      logic [CHANNELS-1:0][FW-1:0] f;
      for (int k = 0; k < CHANNELS; k++) f[k] = CMD_FRAME | FW'(s[k*DATA_W +: DATA_W]);
      return f;
   endfunction

   // Ready depends on state registers only, never on sample_valid
`ifdef SPI_DAC_PENDING_EN
   assign ready_c = (state_q == IDLE) || !pend_full_q;
`else
   assign ready_c = (state_q == IDLE);
`endif
   assign bus.sample_ready = ready_c;

   // State and datapath registers plus registered pad outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         phase_q        <= 1'b0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         bus.spi_le     <= 1'b1;
         bus.spi_clk    <= 1'b0;
         bus.spi_dat    <= '0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overrun    <= 1'b0;
`ifdef SPI_DAC_PENDING_EN
         pend_q         <= '0;
         pend_full_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         phase_q        <= phase_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         bus.spi_le     <= le_d;
         bus.spi_clk    <= sclk_d;
         bus.spi_dat    <= dat_d;
         bus.busy       <= busy_d;
         bus.frame_done <= done_d;
         bus.overrun    <= ovr_d;
`ifdef SPI_DAC_PENDING_EN
         pend_q         <= pend_d;
         pend_full_q    <= pend_full_d;
`endif
      end
   end

   // Next-state: frame load, SCLK half-period timing, bit count, LE width
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
`ifdef SPI_DAC_PENDING_EN
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef SPI_DAC_PENDING_EN
            if (pend_full_q) begin
               state_d     = SHIFT;
               cnt_d       = '0;
               phase_d     = 1'b0;
               bit_cnt_d   = '0;
               shift_d     = build_frame(pend_q);
               pend_d      = bus.sample_in;
               pend_full_d = bus.sample_valid;
            end else
`endif
            if (bus.sample_valid) begin
               state_d   = SHIFT;
               cnt_d     = '0;
               phase_d   = 1'b0;
               bit_cnt_d = '0;
               shift_d   = build_frame(bus.sample_in);
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d   = '0;
               phase_d = ~phase_q;
               if (phase_q) begin
                  for (int k = 0; k < CHANNELS; k++) shift_d[k] = shift_q[k] << 1;
                  if (bit_cnt_q == BIT_W'(FW - 1)) state_d = LATCH;
                  else bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LATCH: begin
            if (cnt_q == CNT_W'(LE_CYCLES - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef SPI_DAC_PENDING_EN
      if (state_q != IDLE && bus.sample_valid && !pend_full_q) begin
         pend_d      = bus.sample_in;
         pend_full_d = 1'b1;
      end
`endif
   end

   // Output values for the next cycle, derived from the next state
   always_comb begin
      le_d   = 1'b1;
      sclk_d = 1'b0;
      dat_d  = '0;
      busy_d = (state_d != IDLE);
      done_d = (state_q == LATCH) && (state_d != LATCH);
      ovr_d  = bus.sample_valid && !ready_c;
      if (state_d == SHIFT) begin
         sclk_d = phase_d;
         for (int k = 0; k < CHANNELS; k++) dat_d[k] = shift_d[k][FW-1];
      end
      if (state_d == LATCH) le_d = 1'b0;
   end
endmodule

// File: doc/spi_dac_multi.md
Name: spi_dac_multi

Overview:
Parametrised serial front-end for N external 12-bit-class DACs (DAC7611-style: shift on SCLK rise, latch on LE low).
- Accepts one parallel sample word per frame through a valid/ready handshake.
- Shifts all channels out simultaneously on a shared SCLK/LE, one data line per channel.
- Adds a programmable SCLK divider, LE width, command prefix, overrun reporting and a frame-done strobe.
- Sits between the audio/sample generator and the chip pads.

Parameters:
CHANNELS, 2, number of DACs / serial data lines (>=1)
DATA_W, 12, sample bits per channel
CMD_W, 4, command prefix bits sent ahead of each sample (0 allowed)
CMD, 4'b0011, command prefix value, MSB first
CLK_DIV, 1, clk cycles per SCLK half-period (>=1)
LE_CYCLES, 1, clk cycles LE is held low per frame (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_in  in  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
sample_valid  in  1  sample_in is valid this cycle
sample_ready  out  1  block accepts sample this cycle (combinational from state regs)
busy  out  1  frame in progress (SHIFT or LATCH)
spi_le  out  1  DAC latch enable, active-low
spi_clk  out  1  shared serial clock
spi_dat  out  CHANNELS  serial data, one bit per channel, MSB first
frame_done  out  1  one-cycle pulse when a frame's LE pulse completes
overrun  out  1  one-cycle pulse when sample_valid is asserted and the sample is dropped

Behaviour:
- FW = CMD_W + DATA_W bits per frame. All outputs registered except sample_ready.
- Reset values: spi_le=1, spi_clk=0, spi_dat=0, busy=0, frame_done=0, overrun=0, state=IDLE, shift regs=0.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: sample_ready=1. On sample_valid, load each channel shift reg with {CMD, sample_k} and go to SHIFT. Accept cycle = T0.
- SHIFT, per bit:
  - Low phase of CLK_DIV cycles: spi_clk=0, spi_dat[k]=shift_k MSB.
  - High phase of CLK_DIV cycles: spi_clk=1, data held stable.
  - Shift left after the high phase.
  - Data changes only while spi_clk=0.
  - First low phase starts T0+1. SHIFT lasts FW*2*CLK_DIV cycles, exactly FW rising edges.
- LATCH: spi_clk=0 and spi_le=0 for LE_CYCLES cycles. The cycle after, spi_le=1, frame_done=1, and the FSM returns to IDLE (sample_ready=1 that cycle).
- Default timing (FW=16, CLK_DIV=1, LE_CYCLES=1): LE low at T0+33, frame_done at T0+34.
- busy=1 from T0+1 through the last LE-low cycle.
- spi_dat returns to 0 in LATCH/IDLE.
- sample_valid while not ready: sample dropped, overrun=1 next cycle, frame in progress unaffected.
- sample_valid with sample_ready: no overrun.
- sample_ready is independent of sample_valid; no combinational path from valid to ready.
- Reset mid-frame:
  - Outputs return to reset values on the next edge.
  - spi_le never pulses for a partial frame, so the DACs keep their old code.
- spi_le is never low while spi_clk=1.
- CMD_W=0: frame is the sample only.

Optional Feature:
Macro: SPI_DAC_PENDING_EN
- Defined:
  - One-deep pending buffer. sample_ready=1 in IDLE, or while busy with the pending buffer empty.
  - A sample accepted during a frame is stored, not dropped.
  - On the frame_done cycle, if pending is full, the pending sample loads and the FSM goes straight to SHIFT. First bit appears the next cycle (back-to-back frames, one spi_le=1 cycle between LE pulses).
  - Overrun only when valid arrives while busy and pending is full.
  - Reset clears pending.
- Not defined: no buffer; behaviour as above.

Test Plan:
1. Defaults, sample_in={12'h123,12'hABC} valid at T0 -> spi_dat[0] sampled on 16 spi_clk rises = 0011_1010_1011_1100, spi_dat[1] = 0011_0001_0010_0011; spi_le=0 only at T0+33; frame_done at T0+34.
2. CLK_DIV=3, LE_CYCLES=2, same sample -> spi_clk high 3 cycles, low 3 cycles, 16 rises; LE low 2 cycles starting T0+97; frame_done at T0+99.
3. sample_valid held high continuously, macro off -> overrun pulses each busy cycle; frames start every 34 cycles; each frame carries the sample present at its accept cycle.
4. Macro on: second sample at T0+5, third at T0+6 -> third gives overrun at T0+7; second frame's first bit at T0+35 with spi_le=1 at T0+34; no overrun for the second sample.
5. rst asserted at T0+10 mid-frame -> next cycle spi_le=1, spi_clk=0, spi_dat=0, busy=0; no LE low pulse; new sample accepted on the first cycle after rst deasserts.
6. CHANNELS=4, CMD_W=0, DATA_W=8, samples 8'h80/8'h01/8'hFF/8'h00 -> 8 rises per frame; per-channel serial streams match exactly.
